// File: rtl/mdu_pkg.sv
// mdu_pkg: opcodes, FSM state encoding and result constants shared by md_unit.
// The DIV state exists only when MDU_DIV_EN is defined.
package mdu_pkg;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;
    localparam logic [31:0] RST_VAL = 32'h0;
`ifdef MDU_DIV_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_FIX = 2'd2, S_DIV = 2'd3} state_e;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_FIX = 2'd2} state_e;
`endif
endpackage

// File: rtl/md_divider.sv
// md_divider: 32-bit unsigned restoring divider, one quotient bit per step.
// Built only when MDU_DIV_EN is defined; signs are handled by md_unit.
`ifdef MDU_DIV_EN
module md_divider (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quo_o,
    output logic [31:0] rem_o
);
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [32:0] trial;
    // quo_q doubles as the dividend shift register; its MSB feeds the partial remainder
    always_comb begin
        trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        if (load_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dvs_d = divisor_i;
        end else if (step_i) begin
            rem_d = trial[32] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
            quo_d = {quo_q[30:0], ~trial[32]};
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end
    assign quo_o = quo_q;
    assign rem_o = rem_q;
endmodule
`endif

// File: rtl/md_unit.sv
// md_unit: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, plus MTHI/MTLO.
// DIV/DIVU are built only when MDU_DIV_EN is defined; otherwise they act as no-ops.
module md_unit
    import mdu_pkg::*;
#(
    parameter int MUL_BITS_PER_CYCLE = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic        flush,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int K  = MUL_BITS_PER_CYCLE;
    localparam int PW = 32 + K;
    localparam logic [4:0] MUL_LAST = 5'(32 / K - 1);
    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] mc_q, mc_d, hi_q, hi_d, lo_q, lo_d;
    logic [63:0] acc_q, acc_d, prod;
    logic        neg_q, neg_d, done_q, done_d;
    logic        accept, sgn;
    logic [31:0] abs_a, abs_b;
    logic [PW-1:0] psum;
    assign accept = start && !flush && state_q == S_IDLE;
    assign sgn    = !mdop[0];
    assign abs_a  = (sgn && a[31]) ? -a : a;
    assign abs_b  = (sgn && b[31]) ? -b : b;
    // low 32 bits of acc_q hold the unretired multiplier bits, upper half the partial product
    assign psum   = PW'(acc_q[63:32]) + PW'(mc_q) * PW'(acc_q[K-1:0]);
    assign prod   = neg_q ? -acc_q : acc_q;
`ifdef MDU_DIV_EN
    logic        is_div_q, is_div_d, aneg_q, aneg_d, bz_q, bz_d;
    logic [31:0] a_q, a_d, quo, rem;
    logic        div_op;
    assign div_op = mdop == OP_DIV || mdop == OP_DIVU;
    md_divider u_div (
        .clk_i     (clock),
        .rst_ni    (reset),
        .load_i    (accept && div_op),
        .step_i    (state_q == S_DIV),
        .dividend_i(abs_a),
        .divisor_i (abs_b),
        .quo_o     (quo),
        .rem_o     (rem)
    );
`endif
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 5'd1;
        mc_d    = mc_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`ifdef MDU_DIV_EN
        is_div_d = is_div_q;
        aneg_d   = aneg_q;
        bz_d     = bz_q;
        a_d      = a_q;
`endif
        case (state_q)
            S_IDLE: if (accept) begin
                cnt_d = '0;
                neg_d = sgn && (a[31] ^ b[31]);
                if (mdop == OP_MULT || mdop == OP_MULTU) begin
                    state_d = S_MUL;
                    mc_d    = abs_a;
                    acc_d   = {32'h0, abs_b};
`ifdef MDU_DIV_EN
                    is_div_d = 1'b0;
                end else if (div_op) begin
                    state_d  = S_DIV;
                    is_div_d = 1'b1;
                    aneg_d   = sgn && a[31];
                    bz_d     = b == 32'h0;
                    a_d      = a;
`endif
                end else begin
                    done_d = 1'b1;
                    hi_d   = mdop == OP_MTHI ? a : hi_q;
                    lo_d   = mdop == OP_MTLO ? a : lo_q;
                end
            end
            S_MUL: begin
                acc_d   = {psum, acc_q[31:K]};
                state_d = cnt_q == MUL_LAST ? S_FIX : S_MUL;
            end
`ifdef MDU_DIV_EN
            S_DIV: state_d = cnt_q == 5'd31 ? S_FIX : S_DIV;
`endif
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                hi_d    = prod[63:32];
                lo_d    = prod[31:0];
`ifdef MDU_DIV_EN
                if (is_div_q) begin
                    lo_d = bz_q ? DIV0_LO : (neg_q ? -quo : quo);
                    hi_d = bz_q ? a_q : (aneg_q ? -rem : rem);
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mc_q    <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            hi_q    <= RST_VAL;
            lo_q    <= RST_VAL;
            done_q  <= 1'b0;
`ifdef MDU_DIV_EN
            is_div_q <= 1'b0;
            aneg_q   <= 1'b0;
            bz_q     <= 1'b0;
            a_q      <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mc_q    <= mc_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
`ifdef MDU_DIV_EN
            is_div_q <= is_div_d;
            aneg_q   <= aneg_d;
            bz_q     <= bz_d;
            a_q      <= a_d;
`endif
        end
    end
    assign busy = state_q != S_IDLE;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed vector table plus control sequences, run on three
// instances with MUL_BITS_PER_CYCLE = 1, 2 and 4.
module tb_md_unit;
    logic clock = 0, reset = 1, start = 0, flush = 0;
    logic [2:0]  mdop = 3'b110;
    logic [31:0] a = 0, b = 0;
    logic [2:0]  busy, done;
    logic [31:0] hi [3];
    logic [31:0] lo [3];
    int total = 0, bad = 0;
    int bn [3], dn [3], da [3];
    logic [31:0] hd [3], ld [3];
    logic [31:0] mhi = 0, mlo = 0, eh, el;
    logic [2:0]  fop;
    bit          nop_div;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        bit          kh, kl;
    } vec_t;
    localparam int NV = 17;
    vec_t vt [NV];
    always #5 clock = ~clock;
    md_unit #(.MUL_BITS_PER_CYCLE(1)) d1 (.clock(clock), .reset(reset), .start(start), .mdop(mdop), .flush(flush),
        .a(a), .b(b), .busy(busy[0]), .done(done[0]), .hi(hi[0]), .lo(lo[0]));
    md_unit #(.MUL_BITS_PER_CYCLE(2)) d2 (.clock(clock), .reset(reset), .start(start), .mdop(mdop), .flush(flush),
        .a(a), .b(b), .busy(busy[1]), .done(done[1]), .hi(hi[1]), .lo(lo[1]));
    md_unit #(.MUL_BITS_PER_CYCLE(4)) d4 (.clock(clock), .reset(reset), .start(start), .mdop(mdop), .flush(flush),
        .a(a), .b(b), .busy(busy[2]), .done(done[2]), .hi(hi[2]), .lo(lo[2]));
    function automatic int exp_busy(logic [2:0] op, int k);
        if (op[2:1] == 2'b00) return 32 / k + 1;
        if (op[2:1] == 2'b01 && DIV_EN) return 33;
        return 0;
    endfunction
    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (bits/cycle=%0d): got %h expected %h", name, k, act, exp);
        end
    endtask
    // fl0: flush together with start; inj: cycle to raise a stray MTHI start; fl: cycle to flush
    task automatic run(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input bit fl0, input int inj, input int fl);
        @(negedge clock);
        start = 1; mdop = op; a = av; b = bv; flush = fl0;
        for (int k = 0; k < 3; k++) begin
            bn[k] = 0; dn[k] = 0; da[k] = 0; hd[k] = 'x; ld[k] = 'x;
        end
        @(posedge clock);
        #1 start = 0; flush = 0; mdop = 3'b110; a = $urandom; b = $urandom;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            for (int k = 0; k < 3; k++) begin
                if (busy[k]) bn[k]++;
                if (done[k]) begin
                    dn[k]++;
                    if (da[k] == 0) begin
                        da[k] = i; hd[k] = hi[k]; ld[k] = lo[k];
                    end
                end
            end
            start = (i == inj);
            flush = (i == fl);
            if (i == inj) begin
                mdop = 3'b100; a = 32'hDEAD_BEEF;
            end
        end
        start = 0; flush = 0;
    endtask
    initial begin
        vt[0]  = '{3'b000, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 0, 0};
        vt[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 0};
        vt[2]  = '{3'b000, 32'd7,        32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD, 0, 0};
        vt[3]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, 0};
        vt[4]  = '{3'b001, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000, 0, 0};
        vt[5]  = '{3'b000, 32'd0,        32'hFFFFFFFF, 32'h00000000, 32'h00000000, 0, 0};
        vt[6]  = '{3'b100, 32'h12345678, 32'd9,        32'h12345678, 32'h0,        0, 1};
        vt[7]  = '{3'b101, 32'h9ABCDEF0, 32'd9,        32'h0,        32'h9ABCDEF0, 1, 0};
        vt[8]  = '{3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0};
        vt[9]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 0};
        vt[10] = '{3'b011, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 0, 0};
        vt[11] = '{3'b010, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 0};
        vt[12] = '{3'b011, 32'hFFFFFFFF, 32'd10,       32'h00000005, 32'h19999999, 0, 0};
        vt[13] = '{3'b010, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 0, 0};
        vt[14] = '{3'b110, 32'h55555555, 32'd1,        32'h0,        32'h0,        1, 1};
        vt[15] = '{3'b111, 32'h55555555, 32'd1,        32'h0,        32'h0,        1, 1};
        vt[16] = '{3'b001, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 0, 0};
        #2 reset = 0;
        repeat (2) @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            chk("reset_busy", 1 << k, 32'(busy[k]), 0);
            chk("reset_done", 1 << k, 32'(done[k]), 0);
            chk("reset_hi", 1 << k, hi[k], 0);
            chk("reset_lo", 1 << k, lo[k], 0);
        end
        reset = 1;
        for (int v = 0; v < NV; v++) begin
            nop_div = vt[v].op[2:1] == 2'b01 && !DIV_EN;
            eh = (vt[v].kh || nop_div) ? mhi : vt[v].hi;
            el = (vt[v].kl || nop_div) ? mlo : vt[v].lo;
            run(vt[v].op, vt[v].a, vt[v].b, 0, -1, -1);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("v%0d_busy_len", v), 1 << k, bn[k], exp_busy(vt[v].op, 1 << k));
                chk($sformatf("v%0d_done_at", v), 1 << k, da[k], exp_busy(vt[v].op, 1 << k) + 1);
                chk($sformatf("v%0d_done_cnt", v), 1 << k, dn[k], 1);
                chk($sformatf("v%0d_hi", v), 1 << k, hd[k], eh);
                chk($sformatf("v%0d_lo", v), 1 << k, ld[k], el);
            end
            mhi = eh; mlo = el;
        end
        // stray MTHI start in cycle 5 of a MULT must be dropped, not queued
        run(3'b000, 32'd3, 32'd5, 0, 5, -1);
        for (int k = 0; k < 3; k++) begin
            chk("ignore_done_cnt", 1 << k, dn[k], 1);
            chk("ignore_done_at", 1 << k, da[k], exp_busy(3'b000, 1 << k) + 1);
            chk("ignore_lo", 1 << k, ld[k], 32'd15);
            chk("ignore_hi_end", 1 << k, hi[k], 32'd0);
        end
        mhi = 0; mlo = 15;
        fop = DIV_EN ? 3'b010 : 3'b000;
        run(fop, 32'd100, 32'd7, 0, -1, 8);
        for (int k = 0; k < 3; k++) begin
            chk("flush_busy_len", 1 << k, bn[k], 8);
            chk("flush_done_cnt", 1 << k, dn[k], 0);
            chk("flush_hi", 1 << k, hi[k], mhi);
            chk("flush_lo", 1 << k, lo[k], mlo);
        end
        run(3'b100, 32'hCAFEF00D, 32'd0, 1, -1, -1);
        for (int k = 0; k < 3; k++) begin
            chk("flush_start_done_cnt", 1 << k, dn[k], 0);
            chk("flush_start_busy", 1 << k, bn[k], 0);
            chk("flush_start_hi", 1 << k, hi[k], mhi);
        end
        run(3'b100, 32'hA5A5A5A5, 32'd0, 0, -1, -1);
        for (int k = 0; k < 3; k++) chk("mthi_hi", 1 << k, hd[k], 32'hA5A5A5A5);
        @(negedge clock);
        start = 1; mdop = 3'b000; a = 32'd3; b = 32'd5;
        @(posedge clock);
        #1 start = 0;
        repeat (5) @(negedge clock);
        for (int k = 0; k < 3; k++) chk("mid_busy", 1 << k, 32'(busy[k]), 1);
        #2 reset = 0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("async_busy", 1 << k, 32'(busy[k]), 0);
            chk("async_done", 1 << k, 32'(done[k]), 0);
            chk("async_hi", 1 << k, hi[k], 0);
            chk("async_lo", 1 << k, lo[k], 0);
        end
        @(negedge clock);
        reset = 1;
        run(3'b001, 32'd6, 32'd7, 0, -1, -1);
        for (int k = 0; k < 3; k++) begin
            chk("post_reset_lo", 1 << k, ld[k], 32'd42);
            chk("post_reset_busy_len", 1 << k, bn[k], exp_busy(3'b001, 1 << k));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
